// File: rtl/fetch_issue_pkg.sv
// Shared widths, opcode constants, FSM/action encodings and the register-read
// table used by the fetch/issue front end.
package fetch_issue_pkg;

    localparam int ISIZE = 16;
    localparam int ASIZE = 16;
    localparam int RSIZE = 4;

    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_JR   = 4'b1110;
    localparam logic [3:0] OP_EXEC = 4'b1111;

    // ADD R0,R0,R0: Rd=0 never matches a forwarding compare
    localparam logic [ISIZE-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } fsm_t;

    typedef enum logic [1:0] {
        ACT_HOLD     = 2'd0,
        ACT_BUBBLE   = 2'd1,
        ACT_REDIRECT = 2'd2,
        ACT_ADVANCE  = 2'd3
    } act_t;

    typedef struct packed {
        logic rd;
        logic rs;
        logic rt;
    } reads_t;

    function automatic reads_t reads_of(input logic [3:0] op);
        reads_t r;
        r.rs = (op <= 4'd9);
        r.rt = (op <= 4'd3);
        r.rd = (op == OP_SW) || (op == OP_JR) || (op == OP_EXEC);
        return r;
    endfunction

endpackage

// File: rtl/fetch_issue_hazard_detect.sv
// Load-use detector: flags when the LW now in EX writes a register that the
// instruction held in ID reads.
module hazard_detect
    import fetch_issue_pkg::*;
(
    input  logic [ISIZE-1:0] id_instr,
    input  logic [ISIZE-1:0] LastInstr,
    input  logic             id_valid,
    input  fsm_t             state,
    output logic             lu_stall
);

    reads_t           use_q;
    logic [RSIZE-1:0] ld_dst;
    logic             unused_bits;

    assign unused_bits = ^LastInstr[7:0];

    always_comb begin
        use_q    = reads_of(id_instr[15:12]);
        ld_dst   = LastInstr[11:8];
        lu_stall = 1'b0;
        // R0 destinations never create a dependency
        if (state == S_RUN && id_valid && LastInstr[15:12] == OP_LW && ld_dst != '0)
            lu_stall = (use_q.rd && id_instr[11:8] == ld_dst) ||
                       (use_q.rs && id_instr[7:4]  == ld_dst) ||
                       (use_q.rt && id_instr[3:0]  == ld_dst);
    end

endmodule

// File: rtl/fetch_issue.sv
// IF stage and IF/ID register: PC, fetch, decode field split, two-deep issue
// history, load-use bubbles and redirect squashing.
module fetch_issue
    import fetch_issue_pkg::*;
#(
    parameter logic [ASIZE-1:0] RESET_PC = '0,
    parameter logic [ISIZE-1:0] NOP      = NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [ASIZE-1:0] imem_addr,
    input  logic [ISIZE-1:0] imem_data,
    input  logic             stall,
    input  logic             redirect_en,
    input  logic [ASIZE-1:0] redirect_pc,
    output logic [3:0]       OpCode,
    output logic [2:0]       Cond,
    output logic [RSIZE-1:0] AddrRd,
    output logic [RSIZE-1:0] AddrRs,
    output logic [RSIZE-1:0] AddrRt,
    output logic [ISIZE-1:0] id_instr,
    output logic [ASIZE-1:0] id_pc1,
    output logic             id_valid,
    output logic [ISIZE-1:0] LastInstr,
    output logic [ISIZE-1:0] Last2Instr,
    output logic             lu_stall
);

    fsm_t             state, state_nxt;
    act_t             act;
    logic [ASIZE-1:0] pc, pc_inc;

    assign pc_inc    = pc + ASIZE'(1);
    assign imem_addr = pc;

    assign OpCode = id_instr[15:12];
    assign Cond   = id_instr[11:9];
    assign AddrRd = id_instr[11:8];
    assign AddrRs = id_instr[7:4];
    assign AddrRt = id_instr[3:0];

    hazard_detect u_hazard (
        .id_instr  (id_instr),
        .LastInstr (LastInstr),
        .id_valid  (id_valid),
        .state     (state),
        .lu_stall  (lu_stall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FILL;
        else        state <= state_nxt;
    end

    // The fill cycle always advances; bubble outranks redirect so the held
    // instruction re-decodes and control re-presents the redirect.
    always_comb begin
        state_nxt = state;
        act       = ACT_ADVANCE;
        if (stall) begin
            act = ACT_HOLD;
        end else if (state == S_FILL) begin
            state_nxt = S_RUN;
        end else if (lu_stall) begin
            act = ACT_BUBBLE;
        end else if (redirect_en) begin
            act = ACT_REDIRECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            id_instr   <= NOP;
            id_pc1     <= RESET_PC;
            id_valid   <= 1'b0;
            LastInstr  <= NOP;
            Last2Instr <= NOP;
        end else begin
            case (act)
                ACT_BUBBLE: begin
                    LastInstr  <= NOP;
                    Last2Instr <= LastInstr;
                end
                ACT_REDIRECT: begin
                    pc         <= redirect_pc;
                    id_instr   <= NOP;
                    id_valid   <= 1'b0;
                    id_pc1     <= pc_inc;
                    LastInstr  <= id_instr;
                    Last2Instr <= LastInstr;
                end
                ACT_ADVANCE: begin
                    pc         <= pc_inc;
                    id_instr   <= imem_data;
                    id_valid   <= 1'b1;
                    id_pc1     <= pc_inc;
                    LastInstr  <= id_instr;
                    Last2Instr <= LastInstr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fetch_issue.md
Name: fetch_issue

Overview:
- IF stage plus IF/ID pipeline register for the 16-bit pipelined CPU.
- Holds the PC and drives instruction memory.
- Registers the fetched instruction and splits it into OpCode/Cond/register-address fields.
- Keeps the two-deep issued-instruction history (LastInstr, Last2Instr) that the combinational control unit uses for forwarding and EXEC detection. Inserts load-use bubbles, and squashes the fetch slot on control-unit redirects.

Parameters:
ISIZE, 16, instruction width.
ASIZE, 16, PC / instruction-memory word-address width.
RSIZE, 4, register-address width.
RESET_PC, 16'h0000, PC value after reset.
NOP, 16'h0000, bubble encoding (ADD R0,R0,R0; Rd=0 never matches a forwarding compare).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  ASIZE  fetch address, equals PC register
imem_data  in  ISIZE  instruction at imem_addr, same-cycle (combinational ROM)
stall  in  1  external freeze (memory wait); holds all state
redirect_en  in  1  control unit: branch taken / JAL / JR / EXEC in ID
redirect_pc  in  ASIZE  target for redirect_en
OpCode  out  4  id_instr[15:12]
Cond  out  3  id_instr[11:9]
AddrRd  out  RSIZE  id_instr[11:8]
AddrRs  out  RSIZE  id_instr[7:4]
AddrRt  out  RSIZE  id_instr[3:0]
id_instr  out  ISIZE  instruction in ID
id_pc1  out  ASIZE  address of ID instruction + 1 (branch base, JAL link)
id_valid  out  1  ID holds a real fetched instruction
LastInstr  out  ISIZE  instruction now in EX
Last2Instr  out  ISIZE  instruction now in MEM
lu_stall  out  1  load-use bubble being inserted this cycle (combinational)

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC.
  - id_instr=LastInstr=Last2Instr=NOP.
  - id_pc1=RESET_PC.
  - id_valid=0.
  - FSM=S_FILL.
- FSM states: S_FILL, S_RUN.
  - S_FILL lasts exactly one non-stalled cycle after reset. The first word is latched into IF/ID, then the FSM goes to S_RUN. lu_stall and redirect_en are ignored in S_FILL.
- Reads-register rules for the ID instruction:
  - Rs is read for OpCode 0..9.
  - Rt is read for OpCode 0..3.
  - Rd is read for OpCode 9 (SW data), 14 (JR) and 15 (EXEC).
- lu_stall = 1 when all of the following hold:
  - S_RUN and id_valid.
  - LastInstr[15:12]==4'b1000 (LW).
  - LastInstr[11:8]!=0.
  - LastInstr[11:8] equals some register the ID instruction reads.
- Per-edge priority, highest first:
  1. stall=1: PC, IF/ID, history, FSM all hold. redirect_en and lu_stall are ignored. Control re-presents redirect because ID is held.
  2. lu_stall=1: PC and IF/ID hold. Last2Instr<=LastInstr, LastInstr<=NOP. redirect_en is ignored; the held instruction re-decodes next cycle. The next cycle's LastInstr is the NOP bubble, so lu_stall never lasts more than 1 cycle.
  3. redirect_en=1:
     - PC<=redirect_pc.
     - id_instr<=NOP, id_valid<=0, id_pc1<=PC+1 (squashes the wrong-path word).
     - LastInstr<=id_instr, Last2Instr<=LastInstr (the redirecting instruction itself issues).
  4. Otherwise:
     - PC<=PC+1 (wraps 16'hFFFF -> 16'h0000).
     - id_instr<=imem_data, id_pc1<=PC+1, id_valid<=1.
     - LastInstr<=id_instr, Last2Instr<=LastInstr.
- Field outputs are pure slices of id_instr, so they are NOP fields (all zero) after reset or a flush.
- Latency:
  - A fetched word is in ID one cycle after imem_addr presents it.
  - It is in LastInstr 2 cycles after fetch and in Last2Instr 3 cycles after fetch (absent stalls).
- Redirect to the current PC value is legal and behaves as above.
- Reset asserted mid-stall or mid-bubble: all state returns to reset values; no bubble carries over.

Decomposition:
- Shared package/define: ISIZE, RSIZE, ASIZE, opcode constants (OP_LW=4'b1000, OP_SW=4'b1001, OP_JR=4'b1110, OP_EXEC=4'b1111), NOP encoding, FSM state encodings.
- One sub-module: hazard_detect. Combinational; inputs id_instr, LastInstr, id_valid, FSM state; output lu_stall. The verifier tests it standalone against the reads-register table.

Test Plan:
- Reset then free-run over IMEM[0..3]=0x0123,0x1456,0x2789,0x3ABC:
  - imem_addr = 0,1,2,3,4 on successive cycles.
  - id_instr=0x0123 with id_valid=1 on cycle 2.
  - LastInstr=0x0123 on cycle 3; Last2Instr=0x0123 on cycle 4.
- LW R3,R1 (0x8310) followed by ADD R4,R3,R2 (0x0432):
  - lu_stall=1 for exactly 1 cycle; PC held one cycle.
  - Next cycle LastInstr=NOP and Last2Instr=0x8310.
  - Repeat with LW R0 as destination: lu_stall stays 0.
- Taken branch in ID, redirect_en=1, redirect_pc=0x0040:
  - Next cycle imem_addr=0x0040, id_instr=NOP, id_valid=0, LastInstr=branch word.
  - 0x0040 word is in ID one cycle later.
- stall=1 for 3 cycles, with redirect_en=1 during the stall:
  - All outputs are frozen for all 3 cycles.
  - Redirect takes effect on the first edge with stall=0.
- Load-use onto JR (LW R5 then 0xE500) with redirect_en=1 simultaneously:
  - Bubble inserted, PC unchanged.
  - Redirect applied the following cycle.
- PC=0xFFFF free-run -> imem_addr wraps to 0x0000. Assert rst_n low during a bubble cycle -> immediate reset values, id_valid=0.
